// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_sequencer : iterative RV32M multiply/divide unit for the execute stage
// Rev 1.0
// ---------------------------------------------------------------------------
module muldiv_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_in,
  input  logic [2:0]  function_in,
  input  logic [31:0] rs1_data_in,
  input  logic [31:0] rs2_data_in,
  input  logic        stall,
  input  logic        invalidate,
  output logic        busy_out,
  output logic        done_out,
  output logic [31:0] result_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  r_state;
  logic [5:0]  r_count;
  logic [63:0] r_acc;     // MUL: {partial high, multiplier}; DIV: {remainder, quotient}
  logic [31:0] r_opb;     // multiplicand or divisor magnitude
  logic [2:0]  r_func;
  logic        r_neg_a;
  logic        r_neg_b;
  logic        r_bypass;  // special-case result already final, skip sign fix-up

  logic        w_a_signed, w_b_signed, w_neg_a, w_neg_b;
  logic [31:0] w_abs_a, w_abs_b;
  logic        w_is_div, w_div_zero, w_overflow;
  logic [32:0] w_mul_sum, w_div_shift, w_div_diff;
  logic        w_div_ok;
  logic [63:0] w_prod;
  logic [31:0] w_quo, w_rem, w_sel;

  always_comb begin
    w_a_signed  = (function_in == 3'd1) || (function_in == 3'd2) ||
                  (function_in == 3'd4) || (function_in == 3'd6);
    w_b_signed  = (function_in == 3'd1) || (function_in == 3'd4) || (function_in == 3'd6);
    w_neg_a     = w_a_signed && rs1_data_in[31];
    w_neg_b     = w_b_signed && rs2_data_in[31];
    w_abs_a     = w_neg_a ? (32'd0 - rs1_data_in) : rs1_data_in;
    w_abs_b     = w_neg_b ? (32'd0 - rs2_data_in) : rs2_data_in;
    w_is_div    = function_in[2];
    w_div_zero  = w_is_div && (rs2_data_in == 32'd0);
    w_overflow  = w_is_div && !function_in[0] &&
                  (rs1_data_in == 32'h8000_0000) && (rs2_data_in == 32'hFFFF_FFFF);
    w_mul_sum   = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_opb : 32'd0)};
    w_div_shift = r_acc[63:31];
    w_div_diff  = w_div_shift - {1'b0, r_opb};
    w_div_ok    = !w_div_diff[32];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= 6'd0;
      r_acc    <= 64'd0;
      r_opb    <= 32'd0;
      r_func   <= 3'd0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_bypass <= 1'b0;
    end else if (invalidate) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_func  <= function_in;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            r_count <= 6'd0;
            if (w_div_zero) begin
              r_acc    <= {rs1_data_in, 32'hFFFF_FFFF};
              r_bypass <= 1'b1;
              r_state  <= S_DONE;
            end else if (w_overflow) begin
              r_acc    <= {32'd0, 32'h8000_0000};
              r_bypass <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_acc    <= {32'd0, (w_is_div ? w_abs_a : w_abs_b)};
              r_opb    <= w_is_div ? w_abs_b : w_abs_a;
              r_bypass <= 1'b0;
              r_state  <= w_is_div ? S_DIV : S_MUL;
            end
          end
        end
        S_MUL: begin
          r_acc   <= {w_mul_sum, r_acc[31:1]};
          r_count <= r_count + 6'd1;
          if (r_count == 6'd31) r_state <= S_DONE;
        end
        S_DIV: begin
          r_acc   <= {(w_div_ok ? w_div_diff[31:0] : w_div_shift[31:0]), r_acc[30:0], w_div_ok};
          r_count <= r_count + 6'd1;
          if (r_count == 6'd31) r_state <= S_DONE;
        end
        S_DONE: begin
          if (!stall) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_prod = (r_neg_a ^ r_neg_b) ? (64'd0 - r_acc) : r_acc;
    w_quo  = (r_bypass || !(r_neg_a ^ r_neg_b)) ? r_acc[31:0] : (32'd0 - r_acc[31:0]);
    w_rem  = (r_bypass || !r_neg_a) ? r_acc[63:32] : (32'd0 - r_acc[63:32]);
    case (r_func)
      3'd0:                w_sel = w_prod[31:0];
      3'd1, 3'd2, 3'd3:    w_sel = w_prod[63:32];
      3'd4, 3'd5:          w_sel = w_quo;
      default:             w_sel = w_rem;
    endcase
    done_out   = (r_state == S_DONE);
    result_out = done_out ? w_sel : 32'd0;
    busy_out   = !reset && !invalidate &&
                 (((r_state == S_IDLE) && start_in) || (r_state == S_MUL) || (r_state == S_DIV));
  end

endmodule
`default_nettype wire
